// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use and mispredict hazards, plus the
// data-memory request/ready handshake with wait-state freeze and timeout trap.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; hazards evaluated, zero-wait accesses pass
// MEM_WAIT | data access outstanding; whole pipeline frozen
// ERR      | memory timed out; frozen until reset, mem_err set
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memread_EX,
  input  logic             branch_MEM,
  input  logic             taken_MEM,
  input  logic             branch_taken_MEM,
  input  logic [31:0]      pc_branch_MEM,
  input  logic [31:0]      pc_seq_MEM,
  input  logic             memread_MEM,
  input  logic             memwrite_MEM,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             flush_exmem,
  output logic             freeze,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  // Wait timer counts down the remaining MEM_WAIT cycles; loaded so that
  // exactly MEM_TIMEOUT wait-state cycles elapse before the trap.
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(MEM_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            mem_err_q;
  logic            mem_acc, mispredict, load_use;

  assign mem_acc    = memread_MEM | memwrite_MEM;
  assign mispredict = branch_MEM & (taken_MEM != branch_taken_MEM);
  assign load_use   = memread_EX & (rd_EX != 5'd0) &
                      ((use_rs1_ID & (rs1_ID == rd_EX)) |
                       (use_rs2_ID & (rs2_ID == rd_EX)));

  assign mem_err = mem_err_q & ~rst;

  // Next state and all pipeline controls; every control is forced low in reset.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    dmem_req       = 1'b0;
    stall_pc       = 1'b0;
    stall_ifid     = 1'b0;
    bubble_idex    = 1'b0;
    flush_ifid     = 1'b0;
    flush_exmem    = 1'b0;
    freeze         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if (rst) begin
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          dmem_req = mem_acc;
          if (mem_acc && !dmem_ready) begin
            freeze       = 1'b1;
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else if (mispredict) begin
            flush_ifid     = 1'b1;
            bubble_idex    = 1'b1;
            flush_exmem    = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = branch_taken_MEM ? pc_branch_MEM : pc_seq_MEM;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            // Completing cycle: pipeline advances, hazards re-evaluated next cycle.
            state_nxt = RUN;
          end else begin
            freeze = 1'b1;
            if (wait_cnt == '0) state_nxt = ERR;
            else wait_cnt_nxt = wait_cnt - WC_W'(1);
          end
        end
        ERR: begin
          freeze = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, wait timer, sticky error and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) mem_err_q <= 1'b1;
      if ((stall_pc | freeze) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_valid && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: single-cycle vector table plus
// hand-written wait-state, timeout, reset and saturation sequences.
module tb_pipe_hazard_ctrl;
  localparam int T_OUT = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk, rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic use_rs1_ID, use_rs2_ID, memread_EX;
  logic branch_MEM, taken_MEM, branch_taken_MEM;
  logic [31:0] pc_branch_MEM, pc_seq_MEM;
  logic memread_MEM, memwrite_MEM, dmem_ready;
  logic dmem_req, stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_exmem;
  logic freeze, redirect_valid, mem_err;
  logic [31:0] redirect_pc;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .memread_EX(memread_EX),
    .branch_MEM(branch_MEM), .taken_MEM(taken_MEM), .branch_taken_MEM(branch_taken_MEM),
    .pc_branch_MEM(pc_branch_MEM), .pc_seq_MEM(pc_seq_MEM),
    .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .bubble_idex(bubble_idex), .flush_ifid(flush_ifid), .flush_exmem(flush_exmem),
    .freeze(freeze), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic [4:0] rs1, rs2;
    logic use1, use2;
    logic [4:0] rd;
    logic mrex, br, tk, btk;
    logic [31:0] pcb, pcs;
    logic mrm, mwm, rdy;
  } in_t;

  typedef struct {
    logic req, spc, sifid, bub, fifid, fexm, frz, rv;
    logic [31:0] rpc;
    logic err;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
    string nm;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit model_ok = 0;
  exp_t exp_q[$];

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic use1, input logic use2,
                             input logic [4:0] rd, input logic mrex,
                             input logic br, input logic tk, input logic btk,
                             input logic [31:0] pcb, input logic [31:0] pcs,
                             input logic mrm, input logic mwm, input logic rdy);
    in_t r;
    r.rst = 1'b0; r.rs1 = rs1; r.rs2 = rs2; r.use1 = use1; r.use2 = use2;
    r.rd = rd; r.mrex = mrex; r.br = br; r.tk = tk; r.btk = btk;
    r.pcb = pcb; r.pcs = pcs; r.mrm = mrm; r.mwm = mwm; r.rdy = rdy;
    return r;
  endfunction

  function automatic exp_t ex(input logic req, input logic spc, input logic sifid,
                              input logic bub, input logic fifid, input logic fexm,
                              input logic frz, input logic rv, input logic [31:0] rpc,
                              input logic err);
    exp_t r;
    r.req = req; r.spc = spc; r.sifid = sifid; r.bub = bub; r.fifid = fifid;
    r.fexm = fexm; r.frz = frz; r.rv = rv; r.rpc = rpc; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input string sig, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, sig, act, want);
    end
  endtask

  task automatic drive(input in_t i);
    rst = i.rst; rs1_ID = i.rs1; rs2_ID = i.rs2; use_rs1_ID = i.use1; use_rs2_ID = i.use2;
    rd_EX = i.rd; memread_EX = i.mrex; branch_MEM = i.br; taken_MEM = i.tk;
    branch_taken_MEM = i.btk; pc_branch_MEM = i.pcb; pc_seq_MEM = i.pcs;
    memread_MEM = i.mrm; memwrite_MEM = i.mwm; dmem_ready = i.rdy;
  endtask

  // One clock: drive after the edge, queue expectations, compare at the falling edge.
  task automatic step(input in_t i, input exp_t e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    drive(i);
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", nm);
    end else begin
      x = exp_q.pop_front();
      chk(nm, "dmem_req", 32'(dmem_req), 32'(x.req));
      chk(nm, "stall_pc", 32'(stall_pc), 32'(x.spc));
      chk(nm, "stall_ifid", 32'(stall_ifid), 32'(x.sifid));
      chk(nm, "bubble_idex", 32'(bubble_idex), 32'(x.bub));
      chk(nm, "flush_ifid", 32'(flush_ifid), 32'(x.fifid));
      chk(nm, "flush_exmem", 32'(flush_exmem), 32'(x.fexm));
      chk(nm, "freeze", 32'(freeze), 32'(x.frz));
      chk(nm, "redirect_valid", 32'(redirect_valid), 32'(x.rv));
      chk(nm, "mem_err", 32'(mem_err), 32'(x.err));
      if (x.rv || i.rst) chk(nm, "redirect_pc", redirect_pc, x.rpc);
      if (model_ok) begin
        chk(nm, "stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk(nm, "flush_cnt", 32'(flush_cnt), 32'(m_flush));
      end
      if (i.rst) begin
        m_stall = 0; m_flush = 0; model_ok = 1;
      end else begin
        if ((x.spc || x.frz) && m_stall < CMAX) m_stall++;
        if (x.rv && m_flush < CMAX) m_flush++;
      end
    end
  endtask

  in_t  idle, rst_in, lu, wv, tw, rv_in;
  exp_t E0, E_ST, E_REQ, E_FRZ, E_ERR;
  vec_t tbl[11];

  task automatic do_reset();
    step(rst_in, E0, "reset");
    step(rst_in, E0, "reset");
  endtask

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_in = idle; rst_in.rst = 1'b1;
    lu     = mk(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    E0     = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_ST   = ex(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    E_REQ  = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_FRZ  = ex(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    E_ERR  = ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);

    tbl[0]  = '{idle, E0, "idle"};
    tbl[1]  = '{lu, E_ST, "load_use_rs2"};
    tbl[2]  = '{mk(0, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1), E_REQ, "hazard_cleared_zero_wait"};
    tbl[3]  = '{mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), E0, "rd_zero"};
    tbl[4]  = '{mk(7, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0), E_ST, "load_use_rs1"};
    tbl[5]  = '{mk(7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0), E0, "rs1_unused"};
    tbl[6]  = '{mk(0, 5, 0, 1, 5, 1, 1, 0, 1, 32'h100, 32'h84, 0, 0, 0),
                ex(0, 0, 0, 1, 1, 1, 0, 1, 32'h100, 0), "mispredict_taken"};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 32'h84, 0, 0, 0),
                ex(0, 0, 0, 1, 1, 1, 0, 1, 32'h84, 0), "mispredict_not_taken"};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h100, 32'h84, 0, 0, 0), E0, "correct_predict"};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h84, 0, 0, 0), E0, "no_branch"};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h200, 32'h84, 1, 0, 1),
                ex(1, 0, 0, 1, 1, 1, 0, 1, 32'h200, 0), "mispredict_zero_wait"};

    drive(rst_in);
    do_reset();
    foreach (tbl[k]) step(tbl[k].i, tbl[k].e, tbl[k].nm);
    step(idle, E0, "counters_after_table");

    // Three wait states with hazards pending; hazards suppressed until the cycle after completion.
    do_reset();
    wv = mk(0, 5, 0, 1, 5, 1, 1, 0, 1, 32'h100, 32'h84, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(wv, E_FRZ, "wait_state");
    wv.rdy = 1'b1;
    step(wv, E_REQ, "wait_complete");
    step(lu, E_ST, "hazard_after_wait");
    step(idle, E0, "wait_idle");

    // Timeout into ERR, sticky until reset.
    do_reset();
    tw = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(tw, E_FRZ, "timeout_enter");
    for (int k = 0; k < T_OUT; k++) step(tw, E_FRZ, "timeout_wait");
    step(tw, E_ERR, "err_state");
    tw.rdy = 1'b1;
    step(tw, E_ERR, "err_sticky");
    rv_in = tw; rv_in.rst = 1'b1;
    step(rv_in, E0, "err_reset");
    step(idle, E0, "err_cleared");

    // Reset in the middle of a wait: request drops, next access starts from RUN.
    tw = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(tw, E_FRZ, "midwait_enter");
    step(tw, E_FRZ, "midwait_wait");
    rv_in = tw; rv_in.rst = 1'b1;
    step(rv_in, E0, "midwait_reset");
    tw.rdy = 1'b1;
    step(tw, E_REQ, "midwait_after_reset");

    // Stall counter saturation.
    do_reset();
    for (int k = 0; k < 20; k++) step(lu, E_ST, "saturate");
    step(idle, E0, "saturated_hold");
    checks++;
    if (stall_cnt !== 4'(CMAX)) begin
      errors++;
      $display("FAIL stall_sat: got %0d expected %0d", stall_cnt, CMAX);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
